flash_arbiter: RTL

FLASH_ARBITER -- requirements
Module: flash_arbiter

---
 rtl/flash_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/flash_arbiter.sv
// flash_arbiter: two-port (A high priority, B low priority) arbiter in front of
// a single flash word reader. Issues one read at a time, retries with a fresh
// flash_cs edge if the reader never answers, and prevents B starvation.
// Optional macro FLASH_ARB_CACHE_EN adds a one-entry per-port read cache.
module flash_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flash_ready,
  input  logic        flash_busy,
  input  logic [15:0] flash_dout,
  output logic        flash_cs,
  output logic [21:0] flash_addr,
  input  logic        a_req,
  input  logic [21:0] a_addr,
  output logic        a_ack,
  output logic [15:0] a_data,
  input  logic        b_req,
  input  logic [21:0] b_addr,
  output logic        b_ack,
  output logic [15:0] b_data
);

  typedef enum logic [2:0] {IDLE, ISSUE, XFER, DONE, GAP} state_t;

  localparam logic [3:0] TLAST = 4'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [3:0] tcnt, tcnt_nxt;   // ISSUE wait count, reused as GAP length count
  logic       cs_nxt;
  logic [2:0] starve;           // consecutive A grants while B waits
  logic       gnt_b;            // current flash grant belongs to B
  logic       pend_a, pend_b, pick_b;
  logic       grant, fin, take_a, take_b;
  logic       hit_a, hit_b;

  // A port is not pending in its own ack cycle
  assign pend_a = a_req & ~a_ack;
  assign pend_b = b_req & ~b_ack;
  assign pick_b = pend_b & (~pend_a | (starve == 3'd4));

`ifdef FLASH_ARB_CACHE_EN
  logic [21:0] a_tag, b_tag;
  logic        a_vld, b_vld;
  logic [15:0] a_cdat, b_cdat;

  assign hit_a = pend_a & a_vld & (a_addr == a_tag);
  assign hit_b = pend_b & b_vld & (b_addr == b_tag);

  // Every completed flash read refreshes the granted port's cache entry
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_tag <= '0; a_vld <= 1'b0; a_cdat <= '0;
      b_tag <= '0; b_vld <= 1'b0; b_cdat <= '0;
    end else if (fin) begin
      if (gnt_b) begin
        b_tag <= flash_addr; b_vld <= 1'b1; b_cdat <= flash_dout;
      end else begin
        a_tag <= flash_addr; a_vld <= 1'b1; a_cdat <= flash_dout;
      end
    end
  end
`else
  assign hit_a = 1'b0;
  assign hit_b = 1'b0;
`endif

  // State, cs and timeout counter registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      tcnt     <= '0;
      flash_cs <= 1'b0;
    end else begin
      state    <= state_nxt;
      tcnt     <= tcnt_nxt;
      flash_cs <= cs_nxt;
    end
  end

  // Next state, cs level and the one-cycle event strobes
  always_comb begin
    state_nxt = state;
    tcnt_nxt  = tcnt;
    cs_nxt    = flash_cs;
    grant     = 1'b0;
    fin       = 1'b0;
    take_a    = 1'b0;
    take_b    = 1'b0;
    case (state)
      IDLE: begin
        if (hit_a) begin
          take_a    = 1'b1;
          state_nxt = DONE;
        end else if (hit_b) begin
          take_b    = 1'b1;
          state_nxt = DONE;
        end else if (flash_ready && (pend_a || pend_b)) begin
          grant     = 1'b1;
          cs_nxt    = 1'b1;
          tcnt_nxt  = '0;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (flash_busy) begin
          tcnt_nxt  = '0;
          state_nxt = XFER;
        end else if (tcnt == TLAST) begin
          tcnt_nxt  = '0;
          cs_nxt    = 1'b0;
          state_nxt = GAP;
        end else begin
          tcnt_nxt  = tcnt + 4'd1;
        end
      end
      XFER: begin
        if (!flash_busy) begin
          fin       = 1'b1;
          cs_nxt    = 1'b0;
          state_nxt = DONE;
        end
      end
      DONE: state_nxt = IDLE;
      GAP: begin
        // two low cycles so the reader sees a fresh rising edge
        if (tcnt == 4'd1) begin
          tcnt_nxt  = '0;
          cs_nxt    = 1'b1;
          state_nxt = ISSUE;
        end else begin
          tcnt_nxt  = tcnt + 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant latch, starvation counter, acks and per-port data registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      flash_addr <= '0;
      gnt_b      <= 1'b0;
      starve     <= '0;
      a_ack      <= 1'b0;
      b_ack      <= 1'b0;
      a_data     <= '0;
      b_data     <= '0;
    end else begin
      if (grant) begin
        flash_addr <= pick_b ? b_addr : a_addr;
        gnt_b      <= pick_b;
      end
      if (!pend_b || (grant && pick_b))
        starve <= '0;
      else if (grant && starve != 3'd4)
        starve <= starve + 3'd1;
      a_ack <= (fin & ~gnt_b) | take_a;
      b_ack <= (fin & gnt_b) | take_b;
      if (fin && !gnt_b) a_data <= flash_dout;
      if (fin && gnt_b)  b_data <= flash_dout;
`ifdef FLASH_ARB_CACHE_EN
      if (take_a) a_data <= a_cdat;
      if (take_b) b_data <= b_cdat;
`endif
    end
  end

endmodule
